// File: rtl/fact_arb_pkg.sv
// ----------------------------------------------------------------------------
// fact_arb_pkg: shared types and constants for the factorial-unit arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fact_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_RANGE   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  // Largest operand whose factorial fits in a 32-bit result.
  localparam int unsigned MAX_N = 12;

endpackage

`default_nettype wire

// File: rtl/fact_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick: combinational round-robin pick starting at the pointer position
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  logic [PW-1:0] w_cand;
  logic          w_found;

  // Scan from the pointer upward, wrapping, and keep the first active request.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = PW'((int'(i_ptr) + i) % NREQ);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        o_idx   = w_cand;
      end
    end
    o_grant[o_idx] = w_found;
    o_any          = w_found;
  end

endmodule

`default_nettype wire

// File: rtl/fact_arbiter.sv
// ----------------------------------------------------------------------------
// fact_arbiter: round-robin sequencer sharing one factorial datapath
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fact_arbiter
  import fact_arb_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int NW      = 4,
  parameter  int DW      = 32,
  parameter  int TIMEOUT = 64,
  localparam int PW      = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  i_req,
  input  logic [NREQ*NW-1:0] i_req_n,
  output logic             o_rsp_valid,
  output logic [PW-1:0]    o_rsp_id,
  output logic [1:0]       o_rsp_status,
  output logic [DW-1:0]    o_rsp_data,
  output logic             o_busy,
  output logic             o_fact_go,
  output logic [NW-1:0]    o_fact_n,
  input  logic             i_fact_done,
  input  logic             i_fact_err,
  input  logic [DW-1:0]    i_fact_result
);

  localparam int            WW        = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] C_TIMEOUT = WW'(TIMEOUT);
  localparam logic [NW-1:0] C_MAX_N   = NW'(MAX_N);
  localparam logic [PW-1:0] C_LAST    = PW'(NREQ - 1);

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic [WW-1:0] r_wd, w_wd_nxt;
  logic [PW-1:0] r_id, w_id_nxt;
  logic [1:0]    r_status, w_status_nxt;
  logic [DW-1:0] r_data, w_data_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_go, w_go_nxt;
  logic [NW-1:0] r_fact_n, w_fact_n_nxt;

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_idx;
  logic            w_any;
  logic [NW-1:0]   w_op;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_op |= i_req_n[i*NW +: NW] & {NW{w_grant[i]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_wd_nxt     = r_wd;
    w_id_nxt     = r_id;
    w_status_nxt = r_status;
    w_data_nxt   = r_data;
    w_fact_n_nxt = r_fact_n;
    w_valid_nxt  = 1'b0;
    w_go_nxt     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_id_nxt     = w_idx;
          w_fact_n_nxt = w_op;
          w_ptr_nxt    = (w_idx == C_LAST) ? '0 : w_idx + 1'b1;
          if (w_op > C_MAX_N) begin
            w_state_nxt  = RESP;
            w_valid_nxt  = 1'b1;
            w_status_nxt = ST_RANGE;
            w_data_nxt   = '0;
          end else begin
            w_state_nxt = ISSUE;
            w_go_nxt    = 1'b1;
          end
        end
      end
      ISSUE: begin
        w_wd_nxt    = '0;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_wd != C_TIMEOUT) begin
          w_wd_nxt = r_wd + 1'b1;
        end
        // Error wins over done, done wins over the watchdog.
        if (i_fact_err) begin
          w_state_nxt  = RESP;
          w_valid_nxt  = 1'b1;
          w_status_nxt = ST_RANGE;
          w_data_nxt   = '0;
        end else if (i_fact_done) begin
          w_state_nxt  = RESP;
          w_valid_nxt  = 1'b1;
          w_status_nxt = ST_OK;
          w_data_nxt   = i_fact_result;
        end else if (r_wd == C_TIMEOUT) begin
          w_state_nxt  = RESP;
          w_valid_nxt  = 1'b1;
          w_status_nxt = ST_TIMEOUT;
          w_data_nxt   = '0;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_wd     <= '0;
      r_id     <= '0;
      r_status <= ST_OK;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_go     <= 1'b0;
      r_fact_n <= '0;
    end else begin
      r_ptr    <= w_ptr_nxt;
      r_wd     <= w_wd_nxt;
      r_id     <= w_id_nxt;
      r_status <= w_status_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
      r_go     <= w_go_nxt;
      r_fact_n <= w_fact_n_nxt;
    end
  end

  assign o_rsp_valid  = r_valid;
  assign o_rsp_id     = r_id;
  assign o_rsp_status = r_status;
  assign o_rsp_data   = r_data;
  assign o_busy       = r_busy;
  assign o_fact_go    = r_go;
  assign o_fact_n     = r_fact_n;

endmodule

`default_nettype wire

// File: tb/tb_fact_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fact_arbiter: directed vector bench for fact_arbiter with a datapath model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fact_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  i_req;
  logic [15:0] i_req_n;
  logic        o_rsp_valid;
  logic [1:0]  o_rsp_id;
  logic [1:0]  o_rsp_status;
  logic [31:0] o_rsp_data;
  logic        o_busy;
  logic        o_fact_go;
  logic [3:0]  o_fact_n;
  logic        i_fact_done;
  logic        i_fact_err;
  logic [31:0] i_fact_result;

  int n_vec = 0;
  int n_bad = 0;

  fact_arbiter #(
    .NREQ    (4),
    .NW      (4),
    .DW      (32),
    .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (i_req),
    .i_req_n       (i_req_n),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_id      (o_rsp_id),
    .o_rsp_status  (o_rsp_status),
    .o_rsp_data    (o_rsp_data),
    .o_busy        (o_busy),
    .o_fact_go     (o_fact_go),
    .o_fact_n      (o_fact_n),
    .i_fact_done   (i_fact_done),
    .i_fact_err    (i_fact_err),
    .i_fact_result (i_fact_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] ops;
    int          dly;
    bit          err;
    bit          iss_done;
    bit          never;
    bit          exp_go;
    logic [1:0]  exp_id;
    logic [1:0]  exp_st;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] r = 32'd1;
    for (int k = 2; k <= int'(n); k++) r = r * k;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Runs cycles until a response, playing the datapath: done (optionally with
  // err) arrives dly cycles after the go pulse. clr: 0 keep req, 1 drop own bit, 2 drop all.
  task automatic run_txn(input bit scramble, input int clr, input int dly, input bit err,
                         input bit iss_done, input bit never,
                         output bit got, output logic [1:0] id, output logic [1:0] st,
                         output logic [31:0] data, output int go_cnt, output int lat,
                         output logic [3:0] fn, output bit hold_ok, output bit busy_ok);
    int cnt = 0;
    bit seen_go = 0;
    got = 0; id = 0; st = 0; data = 0; go_cnt = 0; lat = 0; fn = 0;
    hold_ok = 1; busy_ok = 1;
    for (int s = 1; s <= 40 && !got; s++) begin
      step();
      i_fact_done = 1'b0; i_fact_err = 1'b0; i_fact_result = '0;
      if (seen_go && o_fact_n != fn) hold_ok = 0;
      if (!o_busy) busy_ok = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !never) begin
          i_fact_done = 1'b1; i_fact_err = err; i_fact_result = fact(fn);
        end
      end
      if (o_fact_go) begin
        go_cnt++; seen_go = 1; fn = o_fact_n; cnt = dly;
        if (iss_done) begin
          i_fact_done = 1'b1; i_fact_result = 32'hDEAD_BEEF;
        end
      end
      if (scramble && s == 1) i_req_n = ~i_req_n;
      if (o_rsp_valid) begin
        got = 1; id = o_rsp_id; st = o_rsp_status; data = o_rsp_data; lat = s;
        if (clr == 2) i_req = '0;
        else if (clr == 1) i_req[o_rsp_id] = 1'b0;
      end
    end
    i_fact_done = 1'b0; i_fact_err = 1'b0; i_fact_result = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck, want completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit          got, hold_ok, busy_ok;
    logic [1:0]  id, st;
    logic [31:0] data;
    int          go_cnt, lat;
    logic [3:0]  fn;
    logic [1:0]  rr_id  [5];
    logic [31:0] rr_dat [5];

    tbl[0] = '{4'b0010, 16'h0050, 6, 0, 0, 0, 1, 2'd1, 2'b00, 32'd120,       8};
    tbl[1] = '{4'b1000, 16'hD000, 0, 0, 0, 0, 0, 2'd3, 2'b01, 32'd0,         1};
    tbl[2] = '{4'b0001, 16'h0007, 3, 1, 1, 0, 1, 2'd0, 2'b01, 32'd0,         5};
    tbl[3] = '{4'b0100, 16'h0400, 1, 0, 0, 1, 1, 2'd2, 2'b10, 32'd0,        11};
    tbl[4] = '{4'b0001, 16'h000C, 1, 0, 0, 0, 1, 2'd0, 2'b00, 32'd479001600, 3};
    tbl[5] = '{4'b0101, 16'h0009, 2, 0, 0, 0, 1, 2'd2, 2'b00, 32'd1,         4};
    tbl[6] = '{4'b0011, 16'h0083, 1, 0, 0, 0, 1, 2'd0, 2'b00, 32'd6,         3};
    rr_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_dat = '{32'd1, 32'd2, 32'd6, 32'd24, 32'd1};

    rst_n = 1'b0; i_req = '0; i_req_n = '0;
    i_fact_done = 1'b0; i_fact_err = 1'b0; i_fact_result = '0;
    repeat (2) step();
    check("reset_outs", {o_rsp_valid, o_rsp_id, o_rsp_status, o_rsp_data,
                         o_busy, o_fact_go, o_fact_n}, 64'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      i_req = tbl[i].req; i_req_n = tbl[i].ops;
      run_txn(1, 2, tbl[i].dly, tbl[i].err, tbl[i].iss_done, tbl[i].never,
              got, id, st, data, go_cnt, lat, fn, hold_ok, busy_ok);
      check($sformatf("v%0d_got", i),    got, 1);
      check($sformatf("v%0d_go_cnt", i), go_cnt, tbl[i].exp_go ? 1 : 0);
      if (tbl[i].exp_go)
        check($sformatf("v%0d_fact_n", i), fn, tbl[i].ops[tbl[i].exp_id*4 +: 4]);
      check($sformatf("v%0d_hold", i),   hold_ok, 1);
      check($sformatf("v%0d_busy", i),   busy_ok, 1);
      check($sformatf("v%0d_lat", i),    lat, tbl[i].exp_lat);
      check($sformatf("v%0d_id", i),     id, tbl[i].exp_id);
      check($sformatf("v%0d_status", i), st, tbl[i].exp_st);
      check($sformatf("v%0d_data", i),   data, tbl[i].exp_data);
      step();
      check($sformatf("v%0d_post", i), {o_rsp_valid, o_busy}, 0);
    end

    // Two simultaneous requests right after reset: 0 first, then 2.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    i_req = 4'b0101; i_req_n = 16'h0201;
    run_txn(0, 1, 2, 0, 0, 0, got, id, st, data, go_cnt, lat, fn, hold_ok, busy_ok);
    check("pair_first_id", {got, id, st, data}, {1'b1, 2'd0, 2'b00, 32'd1});
    run_txn(0, 1, 2, 0, 0, 0, got, id, st, data, go_cnt, lat, fn, hold_ok, busy_ok);
    check("pair_second_id", {got, id, st, data}, {1'b1, 2'd2, 2'b00, 32'd2});
    step();
    check("pair_idle", {o_busy, o_rsp_valid}, 0);

    // All four held high: one response each per round.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    i_req = 4'b1111; i_req_n = 16'h4321;
    for (int r = 0; r < 5; r++) begin
      run_txn(0, 0, 1, 0, 0, 0, got, id, st, data, go_cnt, lat, fn, hold_ok, busy_ok);
      check($sformatf("rr%0d_id", r),   {got, id}, {1'b1, rr_id[r]});
      check($sformatf("rr%0d_data", r), data, rr_dat[r]);
      check($sformatf("rr%0d_go", r),   go_cnt, 1);
    end

    // Reset during WAIT drops the transaction and restarts the pointer.
    rst_n = 1'b0; i_req = '0; step(); rst_n = 1'b1;
    i_req = 4'b0010; i_req_n = 16'h0030;
    step();
    check("rst_go", {o_fact_go, o_fact_n}, {1'b1, 4'd3});
    step(); step();
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", {o_rsp_valid, o_rsp_id, o_rsp_status, o_rsp_data,
                             o_busy, o_fact_go, o_fact_n}, 64'd0);
    i_req = 4'b1010; i_req_n = 16'h9020;
    step();
    check("rst_norsp_a", o_rsp_valid, 0);
    step();
    check("rst_norsp_b", o_rsp_valid, 0);
    rst_n = 1'b1;
    run_txn(0, 2, 2, 0, 0, 0, got, id, st, data, go_cnt, lat, fn, hold_ok, busy_ok);
    check("rst_next_rsp", {got, id, st, data}, {1'b1, 2'd1, 2'b00, 32'd2});
    check("rst_next_lat", lat, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
